// File: rtl/wb_protocol_monitor.sv
// wb_protocol_monitor: passive Wishbone pipelined-bus checker with sticky violation flags and traffic counters
module wb_protocol_monitor #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int GRANULE = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH = 16,
  parameter logic [6:0] CHECK_EN = 7'h7F,
  localparam int SEL_WIDTH = DATA_WIDTH / GRANULE,
  localparam int OW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  input  logic [SEL_WIDTH-1:0]  sel_i,
  input  logic                  ack_o,
  input  logic                  err_o,
  input  logic                  stall_o,
  input  logic                  clear_i,
  output logic [6:0]            viol_o,
  output logic                  viol_pulse_o,
  output logic [2:0]            first_viol_o,
  output logic [OW-1:0]         outstanding_o,
  output logic [CNT_WIDTH-1:0]  xfer_cnt_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [OW-1:0] MAX = OW'(MAX_OUTSTANDING);
  typedef enum logic [1:0] {IDLE, ACTIVE, WAIT} state_t;
  state_t state, state_nx;
  logic [OW-1:0] cnt_nx;
  logic [TW-1:0] tmr;
  logic acc, rsp, stalled, stalled_q, we_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic [SEL_WIDTH-1:0] sel_q;
  logic [6:0] raw, v;
  logic [2:0] idx;
  assign acc = cyc_i & stb_i & ~stall_o;
  assign rsp = ack_o | err_o;
  assign stalled = cyc_i & stb_i & stall_o;
  always_comb begin
    cnt_nx = !cyc_i ? '0
           : (acc && !rsp && outstanding_o != MAX) ? outstanding_o + 1'b1
           : (rsp && !acc && outstanding_o != '0) ? outstanding_o - 1'b1
           : outstanding_o;
    state_nx = !cyc_i ? IDLE : cnt_nx != '0 ? WAIT : ACTIVE;
    raw[0] = ack_o & err_o;
    raw[1] = rsp & (outstanding_o == '0 | ~cyc_i);
    raw[2] = state == WAIT && !rsp && tmr == TW'(TIMEOUT_CYCLES - 1);
    raw[3] = stb_i & ~cyc_i;
    raw[4] = ~cyc_i & (outstanding_o != '0);
    raw[5] = stalled & stalled_q & ({adr_i, we_i, dat_i, sel_i} != {adr_q, we_q, dat_q, sel_q});
    raw[6] = acc & (outstanding_o == MAX);
    v = raw & CHECK_EN;
    idx = '0;
    for (int i = 6; i >= 0; i--) if (v[i]) idx = 3'(i);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      outstanding_o <= '0;
      tmr <= '0;
      viol_o <= '0;
      viol_pulse_o <= 1'b0;
      first_viol_o <= '0;
      xfer_cnt_o <= '0;
      err_cnt_o <= '0;
      stall_cnt_o <= '0;
      stalled_q <= 1'b0;
      adr_q <= '0;
      we_q <= 1'b0;
      dat_q <= '0;
      sel_q <= '0;
    end else begin
      state <= state_nx;
      outstanding_o <= cnt_nx;
      // timer saturates at the deadline so the timeout is flagged only once per wait
      tmr <= (state != WAIT || state_nx != WAIT || rsp) ? '0
           : tmr == TW'(TIMEOUT_CYCLES) ? tmr : tmr + 1'b1;
      viol_o <= (clear_i ? '0 : viol_o) | v;
      viol_pulse_o <= |v;
      if (clear_i || viol_o == '0) first_viol_o <= idx;
      xfer_cnt_o <= clear_i ? '0 : xfer_cnt_o + CNT_WIDTH'(ack_o && ~&xfer_cnt_o);
      err_cnt_o <= clear_i ? '0 : err_cnt_o + CNT_WIDTH'(err_o && ~&err_cnt_o);
      stall_cnt_o <= clear_i ? '0 : stall_cnt_o + CNT_WIDTH'(stalled && ~&stall_cnt_o);
      stalled_q <= stalled;
      if (stalled) begin
        adr_q <= adr_i;
        we_q <= we_i;
        dat_q <= dat_i;
        sel_q <= sel_i;
      end
    end
  end
endmodule

// File: tb/tb_wb_protocol_monitor.sv
// tb_wb_protocol_monitor: directed stimulus against two monitors (full and 7'h7E check masks) with a cycle model
module tb_wb_protocol_monitor;
  localparam int TO = 16;
  localparam int MX = 4;
  logic clk = 0, rst = 1, cyc = 0, stb = 0, we = 0, ack = 0, err = 0, stall = 0, clear = 0;
  logic [15:0] adr = 0;
  logic [31:0] dat = 0;
  logic [3:0] sel = 4'hF;
  logic [6:0] viol0, viol1;
  logic pulse0, pulse1;
  logic [2:0] first0, first1, out0, out1;
  logic [15:0] xfer0, xfer1, errc0, errc1, stc0, stc1;
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  wb_protocol_monitor u0 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr), .dat_i(dat),
    .sel_i(sel), .ack_o(ack), .err_o(err), .stall_o(stall), .clear_i(clear), .viol_o(viol0),
    .viol_pulse_o(pulse0), .first_viol_o(first0), .outstanding_o(out0), .xfer_cnt_o(xfer0),
    .err_cnt_o(errc0), .stall_cnt_o(stc0));

  wb_protocol_monitor #(.CHECK_EN(7'h7E)) u1 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr), .dat_i(dat),
    .sel_i(sel), .ack_o(ack), .err_o(err), .stall_o(stall), .clear_i(clear), .viol_o(viol1),
    .viol_pulse_o(pulse1), .first_viol_o(first1), .outstanding_o(out1), .xfer_cnt_o(xfer1),
    .err_cnt_o(errc1), .stall_cnt_o(stc1));

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] lowest(logic [6:0] x);
    for (int i = 0; i < 7; i++) if (x[i]) return 3'(i);
    return 3'd0;
  endfunction

  // model state: in-flight count, response-free wait length, counters, per-mask flags
  int m_out = 0, m_wait = 0, m_xfer = 0, m_errc = 0, m_stc = 0;
  bit m_prev = 0;
  logic [52:0] m_prev_val = 0;
  logic [6:0] m_viol[2] = '{0, 0};
  logic m_pulse[2] = '{0, 0};
  logic [2:0] m_first[2] = '{0, 0};

  always @(posedge clk) begin
    logic [6:0] raw, v;
    bit acc, rsp, stl;
    int nout;
    acc = cyc && stb && !stall;
    rsp = ack || err;
    stl = cyc && stb && stall;
    if (rst) begin
      m_out = 0; m_wait = 0; m_xfer = 0; m_errc = 0; m_stc = 0; m_prev = 0; m_prev_val = 0;
      for (int k = 0; k < 2; k++) begin
        m_viol[k] = 0; m_pulse[k] = 0; m_first[k] = 0;
      end
    end else begin
      raw = 0;
      raw[0] = ack && err;
      raw[1] = rsp && (m_out == 0 || !cyc);
      raw[2] = m_out > 0 && !rsp && m_wait + 1 == TO;
      raw[3] = stb && !cyc;
      raw[4] = !cyc && m_out > 0;
      raw[5] = stl && m_prev && {adr, we, dat, sel} != m_prev_val;
      raw[6] = acc && m_out == MX;
      for (int k = 0; k < 2; k++) begin
        v = raw & (k == 0 ? 7'h7F : 7'h7E);
        if (v != 0 && (clear || m_viol[k] == 0)) m_first[k] = lowest(v);
        else if (clear) m_first[k] = 0;
        m_viol[k] = (clear ? 7'h0 : m_viol[k]) | v;
        m_pulse[k] = v != 0;
      end
      m_xfer = clear ? 0 : (ack && m_xfer < 16'hFFFF) ? m_xfer + 1 : m_xfer;
      m_errc = clear ? 0 : (err && m_errc < 16'hFFFF) ? m_errc + 1 : m_errc;
      m_stc = clear ? 0 : (stl && m_stc < 16'hFFFF) ? m_stc + 1 : m_stc;
      nout = m_out;
      if (!cyc) nout = 0;
      else if (acc && !rsp && m_out < MX) nout = m_out + 1;
      else if (rsp && !acc && m_out > 0) nout = m_out - 1;
      m_wait = (m_out > 0 && nout > 0 && !rsp) ? (m_wait < TO ? m_wait + 1 : TO) : 0;
      m_out = nout;
      m_prev = stl;
      if (stl) m_prev_val = {adr, we, dat, sel};
    end
    #1;
    chk("viol0", viol0, m_viol[0]);
    chk("pulse0", pulse0, m_pulse[0]);
    chk("first0", first0, m_first[0]);
    chk("viol1", viol1, m_viol[1]);
    chk("pulse1", pulse1, m_pulse[1]);
    chk("first1", first1, m_first[1]);
    chk("out0", out0, m_out);
    chk("out1", out1, m_out);
    chk("xfer0", xfer0, m_xfer);
    chk("errc0", errc0, m_errc);
    chk("stc0", stc0, m_stc);
    chk("stc1", stc1, m_stc);
  end

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1; tick(); clear = 0;
  endtask

  initial begin
    tick(2);
    rst = 0;
    tick();
    chk("rst_viol", viol0, 0);
    chk("rst_out", out0, 0);
    chk("rst_xfer", xfer0, 0);
    chk("rst_first", first0, 0);
    // single read, ack two cycles after accept
    cyc = 1; tick();
    stb = 1; tick();
    stb = 0; tick();
    ack = 1; tick(); ack = 0;
    chk("rd_viol", viol0, 0);
    chk("rd_xfer", xfer0, 1);
    chk("rd_out", out0, 0);
    cyc = 0; tick();
    // ack and err together
    do_clear();
    cyc = 1; stb = 1; tick();
    stb = 0; ack = 1; err = 1; tick(); ack = 0; err = 0;
    chk("ae_viol", viol0, 7'h01);
    chk("ae_first", first0, 0);
    chk("ae_pulse", pulse0, 1);
    chk("ae_xfer", xfer0, 1);
    chk("ae_errc", errc0, 1);
    chk("ae_out", out0, 0);
    chk("ae_viol_masked", viol1, 0);
    chk("ae_pulse_masked", pulse1, 0);
    tick();
    chk("ae_pulse_end", pulse0, 0);
    chk("ae_sticky", viol0, 7'h01);
    do_clear();
    chk("clr_viol", viol0, 0);
    chk("clr_xfer", xfer0, 0);
    chk("clr_errc", errc0, 0);
    chk("clr_first", first0, 0);
    // response with nothing outstanding
    ack = 1; tick(); ack = 0;
    chk("orph_viol", viol0, 7'h02);
    chk("orph_first", first0, 1);
    chk("orph_out", out0, 0);
    do_clear();
    // five back-to-back accepts against a limit of four
    stb = 1; tick(5); stb = 0;
    chk("ovf_viol", viol0, 7'h40);
    chk("ovf_out", out0, 4);
    chk("ovf_first", first0, 6);
    ack = 1; tick(4); ack = 0;
    chk("drain_out", out0, 0);
    chk("drain_xfer", xfer0, 4);
    chk("drain_sticky", viol0, 7'h40);
    do_clear();
    // timeout after sixteen response-free cycles, then cyc dropped with a request in flight
    stb = 1; tick(); stb = 0;
    tick(15);
    chk("to_early", viol0, 0);
    chk("to_out", out0, 1);
    tick();
    chk("to_viol", viol0, 7'h04);
    chk("to_pulse", pulse0, 1);
    chk("to_first", first0, 2);
    tick();
    chk("to_once", pulse0, 0);
    tick(5);
    cyc = 0; tick();
    chk("drop_viol", viol0, 7'h14);
    chk("drop_first", first0, 2);
    chk("drop_out", out0, 0);
    do_clear();
    // address changes while stalled
    cyc = 1; stb = 1; stall = 1; adr = 16'h0010; tick(2);
    adr = 16'h0014; tick();
    stall = 0; tick(); stb = 0;
    chk("stl_viol", viol0, 7'h20);
    chk("stl_cnt", stc0, 3);
    chk("stl_first", first0, 5);
    chk("stl_out", out0, 1);
    ack = 1; tick(); ack = 0; cyc = 0; tick();
    chk("stl_out_end", out0, 0);
    // violation on the same edge as clear survives the clear
    stb = 1; clear = 1; tick(); clear = 0; stb = 0;
    chk("clrv_viol", viol0, 7'h08);
    chk("clrv_first", first0, 3);
    chk("clrv_stc", stc0, 0);
    chk("clrv_pulse", pulse0, 1);
    do_clear();
    // reset mid-transaction discards the request without a cyc-drop violation
    cyc = 1; stb = 1; tick(); stb = 0;
    chk("mid_out", out0, 1);
    rst = 1; cyc = 0; tick(); rst = 0; tick();
    chk("mid_viol", viol0, 0);
    chk("mid_out0", out0, 0);
    chk("mid_pulse", pulse0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
